// File: rtl/axis_arbiter_mux_if.sv
// Bundled AXI-Stream signals of the N:1 packet arbiter/mux.
// master = arbiter side; slave = producers plus downstream consumer.
interface axis_arbiter_mux_if #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_INPUTS = 4,
  parameter int IW         = $clog2(NUM_INPUTS)
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] AXIS_IN_TDATA;
  logic [NUM_INPUTS-1:0]            AXIS_IN_TLAST;
  logic [NUM_INPUTS-1:0]            AXIS_IN_TVALID;
  logic [NUM_INPUTS-1:0]            AXIS_IN_TREADY;
  logic [DATA_WIDTH-1:0]            AXIS_OUT_TDATA;
  logic                             AXIS_OUT_TLAST;
  logic                             AXIS_OUT_TVALID;
  logic                             AXIS_OUT_TREADY;
  logic [IW-1:0]                    CURRENT_INPUT;

  modport master (
    input  AXIS_IN_TDATA, AXIS_IN_TLAST, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    output AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
           CURRENT_INPUT
  );

  modport slave (
    output AXIS_IN_TDATA, AXIS_IN_TLAST, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    input  AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
           CURRENT_INPUT
  );
endinterface

// File: rtl/axis_arbiter_mux.sv
// Packet-aware round-robin N:1 AXI-Stream mux with a 2-entry registered skid buffer.
// Latency: 1 cycle arbitration per grant, then 1 cycle input-to-output per beat.
// Backpressure: granted TREADY drops when the skid buffer holds 2 beats; never combinational from output TREADY.
module axis_arbiter_mux #(
  parameter int DATA_WIDTH  = 256,
  parameter int NUM_INPUTS  = 4,
  parameter int PACKET_MODE = 1
) (
  input  logic               clk,
  input  logic               reset,
  axis_arbiter_mux_if.master bus
);
  localparam int IW = $clog2(NUM_INPUTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] dat;
  } beat_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         grant, last_grant;
  logic [IW-1:0]         pick_idx, cand_idx;
  logic                  pick_vld;
  int                    cand;
  logic [NUM_INPUTS-1:0] in_tready;
  logic [1:0]            count;
  beat_t                 ent0, ent1, in_beat;
  logic                  push, pop, rel_beat;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      cand_idx = IW'(cand);
      if (!pick_vld && bus.AXIS_IN_TVALID[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOCKED;
      LOCKED:  if (rel_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_tready = '0;
    if (state == LOCKED && count != 2'd2) in_tready[grant] = 1'b1;
  end

  assign in_beat.dat = bus.AXIS_IN_TDATA[grant*DATA_WIDTH +: DATA_WIDTH];
  assign in_beat.last = bus.AXIS_IN_TLAST[grant];
  assign push     = in_tready[grant] & bus.AXIS_IN_TVALID[grant];
  assign pop      = (count != 2'd0) & bus.AXIS_OUT_TREADY;
  assign rel_beat = push & ((PACKET_MODE == 0) | in_beat.last);

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= IW'(NUM_INPUTS - 1);
    end else begin
      if (state == IDLE && pick_vld) grant <= pick_idx;
      if (rel_beat) last_grant <= grant;
    end
  end

  // ent0 is always the head; a push behind a pop lands where order demands.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_beat;
          else               ent1 <= in_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_beat;
          end else begin
            ent0 <= ent1;
            ent1 <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.AXIS_IN_TREADY  = in_tready;
  assign bus.AXIS_OUT_TVALID = (count != 2'd0);
  assign bus.AXIS_OUT_TDATA  = ent0.dat;
  assign bus.AXIS_OUT_TLAST  = ent0.last;
  assign bus.CURRENT_INPUT   = grant;
endmodule

// File: tb/tb_axis_arbiter_mux.sv
// Directed bench for axis_arbiter_mux: vector table plus multi-cycle sequences.
module tb_axis_arbiter_mux;
  logic clk;
  logic reset;

  axis_arbiter_mux_if #(.DATA_WIDTH(32), .NUM_INPUTS(4)) bus ();
  axis_arbiter_mux_if #(.DATA_WIDTH(32), .NUM_INPUTS(4)) bus0 ();

  axis_arbiter_mux #(.DATA_WIDTH(32), .NUM_INPUTS(4), .PACKET_MODE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  axis_arbiter_mux #(.DATA_WIDTH(32), .NUM_INPUTS(4), .PACKET_MODE(0)) dut_pm0 (
    .clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] dat;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_last;
    logic [1:0]  e_cur;
  } vec_t;

  vec_t tv[9];
  int n_cmp, n_bad, n_acc;
  int beat_cnt[4], pkt_cnt[4], plen[4], npkt[4];
  bit en[4], hold[4];
  bit auto_drv;
  logic [31:0] got_d[$];
  logic        got_l[$];

  function automatic vec_t mkv(logic [3:0] vld, logic [3:0] last, logic [31:0] dat,
                               logic [3:0] e_rdy, logic e_vld, logic [31:0] e_dat,
                               logic e_last, logic [1:0] e_cur);
    vec_t v;
    v.vld = vld; v.last = last; v.dat = dat; v.e_rdy = e_rdy;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_last = e_last; v.e_cur = e_cur;
    return v;
  endfunction

  function automatic logic [31:0] bw(int i, int p, int b);
    return {8'(i), 8'(p), 8'(b), 8'h5A};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_beat(string nm, int k, logic [31:0] ed, logic el);
    if (k < got_d.size()) begin
      chk($sformatf("%s_dat%0d", nm, k), got_d[k], ed);
      chk($sformatf("%s_last%0d", nm, k), 32'(got_l[k]), 32'(el));
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_beat%0d: got no beat, expected %h", nm, k, ed);
    end
  endtask

  task automatic drive();
    if (auto_drv) begin
      for (int i = 0; i < 4; i++) begin
        bus.AXIS_IN_TVALID[i] = en[i] && (pkt_cnt[i] < npkt[i]) && !hold[i];
        bus.AXIS_IN_TLAST[i]  = (beat_cnt[i] == plen[i] - 1);
        bus.AXIS_IN_TDATA[i*32 +: 32] = bw(i, pkt_cnt[i], beat_cnt[i]);
      end
    end
  endtask

  // One clock: note handshakes seen before the edge, advance producers, redrive.
  task automatic tick();
    logic [3:0]  hs;
    logic        pop, ol, rs;
    logic [31:0] od;
    hs  = bus.AXIS_IN_TVALID & bus.AXIS_IN_TREADY;
    pop = bus.AXIS_OUT_TVALID & bus.AXIS_OUT_TREADY;
    od  = bus.AXIS_OUT_TDATA;
    ol  = bus.AXIS_OUT_TLAST;
    rs  = reset;
    @(posedge clk);
    @(negedge clk);
    if (!rs) begin
      if (pop) begin
        got_d.push_back(od);
        got_l.push_back(ol);
      end
      n_acc += $countones(hs);
      if (auto_drv) begin
        for (int i = 0; i < 4; i++) begin
          if (hs[i]) begin
            if (beat_cnt[i] == plen[i] - 1) begin
              beat_cnt[i] = 0;
              pkt_cnt[i]++;
            end else begin
              beat_cnt[i]++;
            end
          end
        end
      end
    end
    drive();
  endtask

  task automatic clr_src();
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; hold[i] = 0; beat_cnt[i] = 0; pkt_cnt[i] = 0; plen[i] = 1; npkt[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    auto_drv = 0;
    bus.AXIS_IN_TVALID = '0;  bus.AXIS_IN_TLAST = '0;  bus.AXIS_IN_TDATA = '0;
    bus0.AXIS_IN_TVALID = '0; bus0.AXIS_IN_TLAST = '0; bus0.AXIS_IN_TDATA = '0;
    bus.AXIS_OUT_TREADY = 1'b1;
    bus0.AXIS_OUT_TREADY = 1'b1;
    clr_src();
    got_d.delete();
    got_l.delete();
    n_acc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //        vld      last     dat    e_rdy    vld  e_dat  lst cur
    tv[0] = mkv(4'b0100, 4'b0000, 32'hA0, 4'b0000, 0, 32'h0,  0, 2'd0);
    tv[1] = mkv(4'b0100, 4'b0000, 32'hA0, 4'b0100, 0, 32'h0,  0, 2'd2);
    tv[2] = mkv(4'b0101, 4'b0001, 32'hA1, 4'b0100, 1, 32'hA0, 0, 2'd2);
    tv[3] = mkv(4'b0101, 4'b0001, 32'hA2, 4'b0100, 1, 32'hA1, 0, 2'd2);
    tv[4] = mkv(4'b0101, 4'b0101, 32'hA3, 4'b0100, 1, 32'hA2, 0, 2'd2);
    tv[5] = mkv(4'b0001, 4'b0001, 32'h0,  4'b0000, 1, 32'hA3, 1, 2'd2);
    tv[6] = mkv(4'b0001, 4'b0001, 32'h0,  4'b0001, 0, 32'h0,  0, 2'd0);
    tv[7] = mkv(4'b0000, 4'b0000, 32'h0,  4'b0000, 1, 32'hB0, 1, 2'd0);
    tv[8] = mkv(4'b0000, 4'b0000, 32'h0,  4'b0000, 0, 32'h0,  0, 2'd0);

    // Single stream on input 2, then a one-beat packet from input 0.
    do_reset();
    for (int r = 0; r < 9; r++) begin
      bus.AXIS_IN_TVALID = tv[r].vld;
      bus.AXIS_IN_TLAST  = tv[r].last;
      bus.AXIS_IN_TDATA  = {32'h0, tv[r].dat, 32'h0, 32'hB0};
      chk($sformatf("vec%0d_tready", r), 32'(bus.AXIS_IN_TREADY), 32'(tv[r].e_rdy));
      chk($sformatf("vec%0d_tvalid", r), 32'(bus.AXIS_OUT_TVALID), 32'(tv[r].e_vld));
      chk($sformatf("vec%0d_cur", r), 32'(bus.CURRENT_INPUT), 32'(tv[r].e_cur));
      if (tv[r].e_vld) begin
        chk($sformatf("vec%0d_tdata", r), bus.AXIS_OUT_TDATA, tv[r].e_dat);
        chk($sformatf("vec%0d_tlast", r), 32'(bus.AXIS_OUT_TLAST), 32'(tv[r].e_last));
      end
      if (r == 0) chk("reset_tdata", bus.AXIS_OUT_TDATA, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end

    // Round-robin among inputs 0,1,3 with back-to-back 3-beat packets.
    do_reset();
    auto_drv = 1;
    en[0] = 1; en[1] = 1; en[3] = 1;
    plen[0] = 3; plen[1] = 3; plen[3] = 3;
    npkt[0] = 2; npkt[1] = 2; npkt[3] = 2;
    drive();
    for (int c = 0; c < 200 && got_d.size() < 18; c++) tick();
    repeat (4) tick();
    chk("rr_count", 32'(got_d.size()), 32'd18);
    for (int k = 0; k < 18; k++) begin
      int ord[3];
      ord = '{0, 1, 3};
      chk_beat("rr", k, bw(ord[(k/3)%3], k/9, k%3), (k%3 == 2));
    end

    // Backpressure mid-packet on an 8-beat packet from input 1.
    do_reset();
    auto_drv = 1;
    en[1] = 1; plen[1] = 8; npkt[1] = 1;
    drive();
    for (int c = 0; c < 20 && got_d.size() < 2; c++) tick();
    begin
      int base;
      bus.AXIS_OUT_TREADY = 1'b0;
      base  = got_d.size();
      n_acc = 0;
      repeat (10) tick();
      chk("bp_acc_le2", 32'(n_acc <= 2), 32'd1);
      chk("bp_tready", 32'(bus.AXIS_IN_TREADY), 32'h0);
      chk("bp_tvalid", 32'(bus.AXIS_OUT_TVALID), 32'd1);
      chk("bp_no_pop", 32'(got_d.size()), 32'(base));
    end
    bus.AXIS_OUT_TREADY = 1'b1;
    for (int c = 0; c < 40 && got_d.size() < 8; c++) tick();
    repeat (3) tick();
    chk("bp_count", 32'(got_d.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk_beat("bp", k, bw(1, 0, k), (k == 7));

    // PACKET_MODE=0: inputs 0 and 1 always valid, never TLAST.
    do_reset();
    bus0.AXIS_IN_TVALID = 4'b0011;
    bus0.AXIS_IN_TLAST  = 4'b0000;
    bus0.AXIS_IN_TDATA  = {32'h0, 32'h0, 32'h22, 32'h11};
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("pm0_k%0d_tvalid", k), 32'(bus0.AXIS_OUT_TVALID), 32'(k % 2 == 0));
      chk($sformatf("pm0_k%0d_cur", k), 32'(bus0.CURRENT_INPUT), 32'(((k - 1) / 2) % 2));
      if (k % 2 == 0)
        chk($sformatf("pm0_k%0d_tdata", k), bus0.AXIS_OUT_TDATA, (k % 4 == 2) ? 32'h11 : 32'h22);
      else
        chk($sformatf("pm0_k%0d_tready", k), 32'(bus0.AXIS_IN_TREADY), 32'(1 << (((k - 1) / 2) % 2)));
    end

    // Reset while LOCKED with the skid buffer full.
    do_reset();
    auto_drv = 1;
    en[2] = 1; plen[2] = 8; npkt[2] = 1;
    bus.AXIS_OUT_TREADY = 1'b0;
    drive();
    for (int c = 0; c < 20 && n_acc < 2; c++) tick();
    chk("rl_pre_acc", 32'(n_acc), 32'd2);
    chk("rl_pre_tready", 32'(bus.AXIS_IN_TREADY), 32'h0);
    chk("rl_pre_tvalid", 32'(bus.AXIS_OUT_TVALID), 32'd1);
    chk("rl_pre_cur", 32'(bus.CURRENT_INPUT), 32'd2);
    reset = 1'b1;
    tick();
    chk("rl_post_tvalid", 32'(bus.AXIS_OUT_TVALID), 32'd0);
    chk("rl_post_tready", 32'(bus.AXIS_IN_TREADY), 32'h0);
    chk("rl_post_cur", 32'(bus.CURRENT_INPUT), 32'd0);
    reset = 1'b0;
    clr_src();
    en[0] = 1; plen[0] = 2; npkt[0] = 1;
    en[2] = 1; plen[2] = 2; npkt[2] = 1;
    bus.AXIS_OUT_TREADY = 1'b1;
    drive();
    tick();
    chk("rl_regrant_cur", 32'(bus.CURRENT_INPUT), 32'd0);
    chk("rl_regrant_tready", 32'(bus.AXIS_IN_TREADY), 32'h1);

    // Granted input stalls TVALID mid-packet while input 1 waits.
    do_reset();
    auto_drv = 1;
    en[0] = 1; plen[0] = 4; npkt[0] = 1;
    en[1] = 1; plen[1] = 2; npkt[1] = 1;
    drive();
    for (int c = 0; c < 20 && beat_cnt[0] < 2; c++) tick();
    chk("gap_start_beats", 32'(beat_cnt[0]), 32'd2);
    hold[0] = 1;
    drive();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("gap%0d_tready1", c), 32'(bus.AXIS_IN_TREADY[1]), 32'd0);
      chk($sformatf("gap%0d_cur", c), 32'(bus.CURRENT_INPUT), 32'd0);
      tick();
    end
    hold[0] = 0;
    drive();
    for (int c = 0; c < 40 && got_d.size() < 6; c++) tick();
    repeat (3) tick();
    chk("gap_count", 32'(got_d.size()), 32'd6);
    for (int k = 0; k < 4; k++) chk_beat("gap", k, bw(0, 0, k), (k == 3));
    for (int k = 4; k < 6; k++) chk_beat("gap", k, bw(1, 0, k - 4), (k == 5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_arbiter_mux.md
Name: axis_arbiter_mux

Overview:
- Parametrised N-input to 1-output AXI-Stream arbiter/multiplexer.
- Packet-aware: grant locks on an input until TLAST, with fair round-robin between inputs.
- Output is registered through a 2-entry skid buffer.
- Merges several producer streams (e.g. data and status) onto one downstream consumer without starvation or interleaving of packets.

Parameters:
- DATA_WIDTH, 256, width of each TDATA bus.
- NUM_INPUTS, 4, number of input streams; legal range 2..16.
- PACKET_MODE, 1, 1 = grant held until a TLAST beat is accepted; 0 = grant released after every accepted beat.
- IW, $clog2(NUM_INPUTS), derived; width of the input index.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- AXIS_IN_TDATA  in  NUM_INPUTS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- AXIS_IN_TLAST  in  NUM_INPUTS  per-input end-of-packet.
- AXIS_IN_TVALID  in  NUM_INPUTS  per-input valid.
- AXIS_IN_TREADY  out  NUM_INPUTS  per-input ready.
- AXIS_OUT_TDATA  out  DATA_WIDTH  output data.
- AXIS_OUT_TLAST  out  1  output end-of-packet.
- AXIS_OUT_TVALID  out  1  output valid.
- AXIS_OUT_TREADY  in  1  downstream ready.
- CURRENT_INPUT  out  IW  index of the granted input; holds last grant while IDLE.

Behaviour:
- Reset: state=IDLE, skid count=0.
  - AXIS_IN_TREADY=0, AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0.
  - CURRENT_INPUT=0; internal last_grant=NUM_INPUTS-1, so input 0 has first priority.
- Reset asserted mid-packet discards the skid contents and the grant. No partial-packet recovery; upstream must also be reset.
- State IDLE:
  - All TREADY=0.
  - If any TVALID=1, select the first asserted input searching last_grant+1, +2, … with wrap modulo NUM_INPUTS.
  - Register the selection into grant and CURRENT_INPUT; go to LOCKED next cycle.
  - Arbitration costs exactly one cycle per grant.
- State LOCKED:
  - AXIS_IN_TREADY[grant] = (count<2); all other TREADY bits = 0.
  - TREADY is a combinational function of the registered count only; it never depends on AXIS_OUT_TREADY.
  - A beat is accepted when TVALID[grant] & TREADY[grant]; it is written into the skid buffer.
  - Release on acceptance of a beat with TLAST=1 (PACKET_MODE=1), or of any beat (PACKET_MODE=0).
  - On release: last_grant<=grant, state<=IDLE; that input gets lowest priority in the next arbitration.
  - TVALID deassertion while LOCKED does not release the grant. A packet must complete.
- Skid buffer (2 entries, FIFO order):
  - AXIS_OUT_TVALID = (count!=0); TDATA/TLAST come from the head entry.
  - Pop on AXIS_OUT_TVALID & AXIS_OUT_TREADY.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push when count==2 cannot occur, because TREADY is 0 then.
- Latency and throughput:
  - A beat accepted on edge N is visible on the output after edge N, i.e. 1-cycle latency when the buffer is empty.
  - Sustained rate is 1 beat/cycle within a packet; one idle cycle between grants.
  - PACKET_MODE=0 therefore gives at most 50% throughput; this is accepted.
- Data on non-granted inputs is ignored. Output TDATA changes only on push/pop, never combinationally from inputs.
- Boundaries:
  - Single-beat packet (TLAST on first beat): LOCKED lasts one acceptance, then IDLE.
  - AXIS_OUT_TREADY held low: count reaches 2, granted TREADY drops. There is no loss and no duplication.
  - Only one requester: it is re-granted after each one-cycle IDLE gap.

Test Plan:
- Reset then single stream, NUM_INPUTS=4, DATA_WIDTH=32, PACKET_MODE=1: input 2 sends 0xA0..0xA3 with TLAST on 0xA3 and OUT_TREADY=1 -> output shows 0xA0..0xA3 on consecutive cycles, TLAST only on 0xA3, first beat 2 cycles after TVALID rises, CURRENT_INPUT=2.
- Round-robin fairness: inputs 0,1,3 each hold 3-beat packets continuously valid -> packet order 0,1,3,0,1,3; no beats interleaved between packets.
- Backpressure: OUT_TREADY=0 for 10 cycles mid-packet -> count saturates at 2, TREADY[grant]=0 within 2 accepted beats; after release, all 8 beats of the packet emerge in order, none lost or duplicated.
- PACKET_MODE=0 with inputs 0 and 1 always valid, TLAST=0 -> output alternates input 0 and input 1 beats, one beat per 2 cycles.
- Reset asserted while LOCKED with count=2 -> next cycle AXIS_OUT_TVALID=0, all TREADY=0, CURRENT_INPUT=0; the next arbitration grants input 0 if it is valid.
- Granted input drops TVALID for 5 cycles mid-packet while input 1 is valid -> grant stays; input 1 TREADY stays 0 until the granted packet's TLAST is accepted.
